// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out serializer.
package piso_pkg;

  // Default serial word width in bits.
  localparam int unsigned MsbDefault = 8;

  // Serializer control states.
  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Load/serial bus of the serializer: parallel load handshake in, serial bit stream out.
interface piso_serializer_if
  import piso_pkg::*;
#(
  parameter int unsigned MSB = MsbDefault
) ();

  logic           en;
  logic           dir;
  logic           load_valid;
  logic [MSB-1:0] load_data;
  logic           load_ready;
  logic           dout;
  logic           dout_valid;
  logic           busy;
  logic           done;

  // Producer side: offers words and paces the bit stream.
  modport master (
    output en, dir, load_valid, load_data,
    input  load_ready, dout, dout_valid, busy, done
  );

  // Serializer side.
  modport slave (
    input  en, dir, load_valid, load_data,
    output load_ready, dout, dout_valid, busy, done
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shift register with selectable bit order and enable-paced output.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned MSB = MsbDefault
) (
  input logic             clk,
  input logic             rst,
  piso_serializer_if.slave bus
);

  localparam int unsigned CntW = $clog2(MSB + 1);

  state_e          state_q, state_d;
  logic [MSB-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            done_q, done_d;

  // State register; reset aborts any frame in progress without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Next-state: load in idle, shift toward the output end on each enabled cycle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load_valid) begin
          state_d = StShift;
          shreg_d = bus.load_data;
          dir_d   = bus.dir;
          cnt_d   = CntW'(MSB);
        end
      end
      StShift: begin
        if (bus.en) begin
          // The final shift also flushes the register to zero and the counter to 0.
          shreg_d = dir_q ? {1'b0, shreg_q[MSB-1:1]} : {shreg_q[MSB-2:0], 1'b0};
          cnt_d   = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state; done is itself registered.
  always_comb begin
    bus.load_ready = (state_q == StIdle);
    bus.busy       = (state_q == StShift);
    bus.dout_valid = (state_q == StShift);
    bus.dout       = (state_q == StShift) & (dir_q ? shreg_q[0] : shreg_q[MSB-1]);
    bus.done       = done_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: constant vectors, corner sequences, random loopback.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  piso_serializer_if #(.MSB(W)) bus ();

  piso_serializer #(.MSB(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors;
  int checks;

  // Reference model: queue of bits still to be emitted in output order.
  logic         mq[$];
  logic         m_done;
  logic [W-1:0] m_word;
  logic         m_dir;
  // Serial-in register fed by the DUT stream (loopback).
  logic [W-1:0] si;

  typedef struct {
    logic [W-1:0] data;
    logic         dir;
    logic [W-1:0] stream;  // expected bits, first bit at [W-1]
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.load_ready, bus.busy, bus.dout_valid, bus.dout, bus.done};
  endfunction

  function automatic logic [4:0] model_outs();
    logic b;
    b = (mq.size() != 0);
    return {!b, b, b, b ? mq[0] : 1'b0, m_done};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_done = 1'b0;
  endtask

  // Apply one cycle of inputs, advance model and loopback, then compare.
  task automatic cyc(input logic lv, input logic [W-1:0] d, input logic dr, input logic e);
    logic pre_dout;
    logic pre_valid;
    logic b;
    bus.load_valid = lv;
    bus.load_data  = d;
    bus.dir        = dr;
    bus.en         = e;
    #1;
    pre_dout  = bus.dout;
    pre_valid = bus.dout_valid;
    @(posedge clk);
    if (pre_valid && e) begin
      if (m_dir) si = {pre_dout, si[W-1:1]};
      else       si = {si[W-2:0], pre_dout};
    end
    m_done = 1'b0;
    if (mq.size() == 0) begin
      if (lv) begin
        for (int i = 0; i < W; i++) mq.push_back(dr ? d[i] : d[W-1-i]);
        m_word = d;
        m_dir  = dr;
        si     = '0;
      end
    end else if (e) begin
      b = mq.pop_front();
      if (mq.size() == 0) m_done = 1'b1;
    end
    #1;
    chk("outputs", {3'b0, outs()}, {3'b0, model_outs()});
    if (m_done) chk("loopback", si, m_word);
  endtask

  initial begin
    logic [W-1:0] w;
    logic         dr;
    int           budget;
    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst = 1'b0;
    bus.en = 1'b0;
    bus.dir = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    si = '0;
    m_word = '0;
    m_dir = 1'b0;
    model_reset();

    tbl[0] = '{data: 8'hB4, dir: 1'b0, stream: 8'b1011_0100};
    tbl[1] = '{data: 8'hB4, dir: 1'b1, stream: 8'b0010_1101};
    tbl[2] = '{data: 8'h5A, dir: 1'b0, stream: 8'b0101_1010};
    tbl[3] = '{data: 8'h0F, dir: 1'b0, stream: 8'b0000_1111};
    tbl[4] = '{data: 8'h01, dir: 1'b0, stream: 8'b0000_0001};
    tbl[5] = '{data: 8'h01, dir: 1'b1, stream: 8'b1000_0000};

    // Reset state
    #12;
    chk("reset_outs", {3'b0, outs()}, {3'b0, 5'b10000});
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b1);  // en in idle does nothing

    // Table vectors with en held high
    for (int t = 0; t < 6; t++) begin
      cyc(1'b1, tbl[t].data, tbl[t].dir, 1'b1);
      for (int k = 0; k < W; k++) begin
        chk($sformatf("tbl%0d_bit%0d", t, k), {7'b0, bus.dout}, {7'b0, tbl[t].stream[W-1-k]});
        cyc(1'b0, '0, ~tbl[t].dir, 1'b1);
      end
      chk($sformatf("tbl%0d_done", t), {6'b0, bus.done, bus.load_ready}, 8'h03);
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_done_clr", t), {7'b0, bus.done}, 8'h00);
    end

    // en gaps: each bit held while en is low
    cyc(1'b1, 8'hB4, 1'b0, 1'b0);
    for (int k = 0; k < W; k++) begin
      repeat (2) begin
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("gap_hold", {7'b0, bus.dout}, {7'b0, tbl[0].stream[W-1-k]});
      end
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
    chk("gap_done", {7'b0, bus.done}, 8'h01);

    // Load during frame is ignored
    cyc(1'b1, 8'h0F, 1'b0, 1'b1);
    for (int k = 0; k < W; k++) begin
      chk("ign_bit", {7'b0, bus.dout}, {7'b0, tbl[3].stream[W-1-k]});
      cyc(1'b1, 8'hFF, 1'b0, 1'b1);
    end
    chk("ign_done", {6'b0, bus.done, bus.load_ready}, 8'h03);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame
    cyc(1'b1, 8'hB4, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1 chk("async_rst", {3'b0, outs()}, {3'b0, 5'b10000});
    model_reset();
    @(posedge clk);
    #1 chk("rst_held", {3'b0, outs()}, {3'b0, 5'b10000});
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 8'h5A, 1'b0, 1'b1);
    for (int k = 0; k < W; k++) begin
      chk("post_rst_bit", {7'b0, bus.dout}, {7'b0, tbl[2].stream[W-1-k]});
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
    chk("post_rst_done", {7'b0, bus.done}, 8'h01);

    // Random loopback with random en, spurious loads and dir toggles
    for (int n = 0; n < 100; n++) begin
      w  = W'($urandom);
      dr = 1'($urandom);
      cyc(1'b1, w, dr, 1'($urandom));
      budget = 0;
      while (mq.size() != 0 && budget < 200) begin
        cyc(1'($urandom), W'($urandom), 1'($urandom), ($urandom_range(3) != 0));
        budget++;
      end
      if (budget >= 200) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout got=busy exp=idle word=%h", w);
      end
      if ($urandom_range(3) == 0) cyc(1'b0, '0, 1'b0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
